// File: rtl/chip8_mem_arbiter_if.sv
// Memory-side bus of the CHIP-8 memory arbiter: one read port with a data-valid
// acknowledge and one write port, matching the existing `memory` block handshake.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();
  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_read_ack;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;

  // Arbiter side drives the strobes and addresses.
  modport master (
    output mem_read,
    output mem_read_addr,
    input  mem_read_data,
    input  mem_read_ack,
    output mem_write,
    output mem_write_addr,
    output mem_write_data
  );

  // Memory side returns read data and its acknowledge.
  modport slave (
    input  mem_read,
    input  mem_read_addr,
    output mem_read_data,
    output mem_read_ack,
    input  mem_write,
    input  mem_write_addr,
    input  mem_write_data
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Round-robin N-channel arbiter sharing the single-port CHIP-8 memory; one
// transaction at a time, with a read timeout that forces completion.
module chip8_mem_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ack,
  chip8_mem_arbiter_if.master      mem,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  logic [2:0]        state;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] read_addr_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] write_data_q;

  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [CH_W-1:0]   pick;

  assign req = ch_read | ch_write;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx[CH_W-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[CH_W-1:0];
      end
    end
  end

  // Outputs decode from the state register only; nothing from ch_* reaches mem_*.
  assign mem.mem_read       = (state == S_READ);
  assign mem.mem_write      = (state == S_WRITE);
  assign mem.mem_read_addr  = read_addr_q;
  assign mem.mem_write_addr = write_addr_q;
  assign mem.mem_write_data = write_data_q;
  assign busy               = (state != S_IDLE);
  assign ch_ack             = (state == S_ACK) ? (NUM_CH'(1) << gnt) : '0;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      gnt          <= '0;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      ch_rdata     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt <= pick;
            // A write wins when a channel raises both read and write.
            if (ch_write[pick]) begin
              write_addr_q <= ch_addr[pick*ADDR_W +: ADDR_W];
              write_data_q <= ch_wdata[pick*DATA_W +: DATA_W];
              state        <= S_WRITE;
            end else begin
              read_addr_q <= ch_addr[pick*ADDR_W +: ADDR_W];
              state       <= S_READ;
            end
          end
        end
        S_WRITE: state <= S_ACK;
        S_READ: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // The acknowledge is tested first so it beats a same-cycle timeout.
          if (mem.mem_read_ack) begin
            ch_rdata <= mem.mem_read_data;
            state    <= S_ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            ch_rdata    <= '1;
            timeout_err <= 1'b1;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          rr_ptr <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: directed scenarios followed by
// randomized multi-channel traffic scored against a transaction-level model.
`timescale 1ns/1ps
module tb_chip8_mem_arbiter;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        ch_read = '0;
  logic [NUM_CH-1:0]        ch_write = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
  logic [NUM_CH*DATA_W-1:0] ch_wdata = '0;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     busy;
  logic                     timeout_err;

  chip8_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  chip8_mem_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_ack(ch_ack),
    .mem(mif),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: unwritten locations read as addr[7:0]^0xA0; mem_lat=0 never answers.
  logic [7:0]        mem_arr [4096];
  bit                mem_valid [4096];
  int                mem_lat = 1;
  bit                pend = 1'b0;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;

  always @(negedge clk) begin
    mif.mem_read_ack = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (mif.mem_write) begin
        mem_arr[mif.mem_write_addr]   = mif.mem_write_data;
        mem_valid[mif.mem_write_addr] = 1'b1;
      end
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          mif.mem_read_ack  = 1'b1;
          mif.mem_read_data = mem_valid[pend_addr] ? mem_arr[pend_addr]
                                                   : (pend_addr[7:0] ^ 8'hA0);
          pend = 1'b0;
        end
      end
      if (mif.mem_read && mem_lat > 0) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = mif.mem_read_addr;
      end
    end
  end

  // Reference view of memory and arbiter state, kept at transaction level.
  logic [7:0]        ref_mem [4096];
  logic [7:0]        last_rdata;
  int                model_rr;
  logic [ADDR_W-1:0] pool [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ch_read[ch]                  = rd;
    ch_write[ch]                 = wr;
    ch_addr[ch*ADDR_W +: ADDR_W] = a;
    ch_wdata[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_ack(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ch_ack == '0 && cyc < max_cyc);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Test state
  int                cyc, cnt, rd_cnt, wr_cnt, ack_cnt, g, opsel;
  logic [ADDR_W-1:0] seen_addr;
  logic [DATA_W-1:0] seen_data, exp_rdata;
  bit                op_wr [NUM_CH];
  logic [NUM_CH-1:0] rnd_pend;
  logic [1:0]        rq_op [NUM_CH];
  logic [ADDR_W-1:0] rq_addr [NUM_CH];
  logic [DATA_W-1:0] rq_data [NUM_CH];
  int                cur_lat;
  bit                exp_terr;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = i[7:0] ^ 8'hA0;
    for (int i = 0; i < 8; i++) pool[i] = ADDR_W'(12'h200 + i * 12'h111);
    last_rdata = 8'h00;
    exp_terr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ch_ack, 0);
    check("rst_mem_read", mif.mem_read, 0);
    check("rst_mem_write", mif.mem_write, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_rdata", ch_rdata, 0);
    rst_n = 1'b1;

    // 1: ch1 write 0x200/0xA5
    step();
    set_req(1, 1'b0, 1'b1, 12'h200, 8'hA5);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    @(negedge clk);
    check("t1_mem_write", mif.mem_write, 1);
    check("t1_waddr", mif.mem_write_addr, 12'h200);
    check("t1_wdata", mif.mem_write_data, 8'hA5);
    check("t1_no_early_ack", ch_ack, 0);
    check("t1_busy1", busy, 1);
    @(negedge clk);
    check("t1_ack", ch_ack, 3'b010);
    check("t1_write_one_cycle", mif.mem_write, 0);
    check("t1_busy2", busy, 1);
    step();
    set_req(1, 1'b0, 1'b0, 12'h200, 8'hA5);
    ref_mem[12'h200] = 8'hA5;
    @(negedge clk);
    check("t1_ack_one_cycle", ch_ack, 0);
    check("t1_busy_done", busy, 0);
    check("t1_waddr_hold", mif.mem_write_addr, 12'h200);
    model_rr = 2;

    // 2: ch0 read 0x050, memory answers 0xF0 one cycle after mem_read
    mem_lat = 1;
    step();
    set_req(0, 1'b1, 1'b0, 12'h050, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("t2_mem_read", mif.mem_read, 1);
    check("t2_raddr", mif.mem_read_addr, 12'h050);
    @(negedge clk);
    check("t2_read_one_cycle", mif.mem_read, 0);
    check("t2_no_early_ack", ch_ack, 0);
    @(negedge clk);
    check("t2_ack", ch_ack, 3'b001);
    check("t2_rdata", ch_rdata, 8'hF0);
    check("t2_terr", timeout_err, 0);
    step();
    set_req(0, 1'b0, 1'b0, 12'h050, 8'h00);
    last_rdata = 8'hF0;

    // 3: all channels request continuously from reset, alternating op types
    rst_n = 1'b0;
    mem_lat = 2;
    last_rdata = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      op_wr[c] = (c % 2 == 0);
      set_req(c, !op_wr[c], op_wr[c], ADDR_W'(12'h100 + c), DATA_W'(8'h30 + c));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(40, cyc);
      check($sformatf("t3_grant%0d", k), ch_ack, NUM_CH'(1) << (k % NUM_CH));
      g = k % NUM_CH;
      if (op_wr[g]) ref_mem[12'h100 + g] = DATA_W'(8'h30 + g);
      else last_rdata = ref_mem[12'h100 + g];
      check($sformatf("t3_rdata%0d", k), ch_rdata, last_rdata);
      step();
      if (k < 5) begin
        op_wr[g] = !op_wr[g];
        set_req(g, !op_wr[g], op_wr[g], ADDR_W'(12'h100 + g), DATA_W'(8'h30 + g));
      end else begin
        ch_read  = '0;
        ch_write = '0;
      end
    end

    // 4: ch2 read with no memory answer: forced completion after 16 WAIT cycles
    mem_lat = 0;
    step();
    set_req(2, 1'b1, 1'b0, 12'h0AB, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("t4_mem_read", mif.mem_read, 1);
    cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (ch_ack == '0 && busy && !mif.mem_read && !timeout_err) cnt++;
    end
    check("t4_wait_cycles", cnt, TIMEOUT);
    @(negedge clk);
    check("t4_ack", ch_ack, 3'b100);
    check("t4_rdata", ch_rdata, 8'hFF);
    check("t4_terr", timeout_err, 1);
    step();
    set_req(2, 1'b0, 1'b0, 12'h0AB, 8'h00);
    repeat (3) @(negedge clk);
    check("t4_terr_sticky", timeout_err, 1);

    // 5: move rr_ptr to 2, then reset asynchronously in the middle of a WAIT
    step();
    set_req(1, 1'b0, 1'b1, 12'h123, 8'h77);
    wait_ack(10, cyc);
    check("t5_pre_ack", ch_ack, 3'b010);
    ref_mem[12'h123] = 8'h77;
    step();
    set_req(1, 1'b0, 1'b0, 12'h123, 8'h77);
    set_req(0, 1'b1, 1'b0, 12'h050, 8'h00);
    repeat (4) @(negedge clk);
    check("t5_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy_async", busy, 0);
    check("t5_ack_async", ch_ack, 0);
    check("t5_read_async", mif.mem_read, 0);
    check("t5_terr_async", timeout_err, 0);
    check("t5_rdata_async", ch_rdata, 0);
    set_req(0, 1'b0, 1'b0, 12'h050, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ch_ack != '0) ack_cnt++;
    end
    check("t5_no_ack_after_rst", ack_cnt, 0);
    step();
    set_req(1, 1'b0, 1'b1, 12'h124, 8'h21);
    set_req(2, 1'b0, 1'b1, 12'h125, 8'h22);
    wait_ack(10, cyc);
    check("t5_first_grant", ch_ack, 3'b010);
    check("t5_rdata_keep", ch_rdata, last_rdata);
    step();
    set_req(1, 1'b0, 1'b0, 12'h124, 8'h21);
    wait_ack(10, cyc);
    check("t5_second_grant", ch_ack, 3'b100);
    step();
    set_req(2, 1'b0, 1'b0, 12'h125, 8'h22);
    ref_mem[12'h124] = 8'h21;
    ref_mem[12'h125] = 8'h22;

    // 6: read+write together -> write only; then ack coincident with timeout limit
    step();
    set_req(0, 1'b1, 1'b1, 12'h300, 8'h11);
    rd_cnt = 0;
    wr_cnt = 0;
    seen_addr = '0;
    seen_data = '0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mif.mem_read) rd_cnt++;
      if (mif.mem_write) begin
        wr_cnt++;
        seen_addr = mif.mem_write_addr;
        seen_data = mif.mem_write_data;
      end
    end while (ch_ack == '0 && cyc < 12);
    check("t6_ack", ch_ack, 3'b001);
    check("t6_write_count", wr_cnt, 1);
    check("t6_read_count", rd_cnt, 0);
    check("t6_waddr", seen_addr, 12'h300);
    check("t6_wdata", seen_data, 8'h11);
    step();
    set_req(0, 1'b0, 1'b0, 12'h300, 8'h11);
    ref_mem[12'h300] = 8'h11;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ch_ack != '0) ack_cnt++;
    end
    check("t6_single_ack", ack_cnt, 0);
    mem_lat = TIMEOUT;
    step();
    set_req(0, 1'b1, 1'b0, 12'h300, 8'h00);
    wait_ack(40, cyc);
    check("t6_coincide_ack", ch_ack, 3'b001);
    check("t6_coincide_latency", cyc, TIMEOUT + 3);
    check("t6_coincide_rdata", ch_rdata, ref_mem[12'h300]);
    check("t6_coincide_terr", timeout_err, 0);
    last_rdata = ref_mem[12'h300];
    step();
    set_req(0, 1'b0, 1'b0, 12'h300, 8'h00);
    model_rr = 1;

    // Randomized traffic: random channel sets, ops, addresses and memory latencies
    for (int r = 0; r < 40; r++) begin
      step();
      rnd_pend = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      cur_lat  = $urandom_range(0, TIMEOUT + 2);
      mem_lat  = cur_lat;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rnd_pend[c]) begin
          opsel      = $urandom_range(0, 2);
          rq_op[c]   = 2'(opsel);
          rq_addr[c] = pool[$urandom_range(0, 7)];
          rq_data[c] = DATA_W'($urandom);
          set_req(c, rq_op[c] != 2'd1, rq_op[c] != 2'd0, rq_addr[c], rq_data[c]);
        end
      end
      while (rnd_pend != '0) begin
        g = -1;
        for (int off = NUM_CH - 1; off >= 0; off--)
          if (rnd_pend[(model_rr + off) % NUM_CH]) g = (model_rr + off) % NUM_CH;
        wait_ack(60, cyc);
        check($sformatf("rnd%0d_ack", r), ch_ack, NUM_CH'(1) << g);
        if (rq_op[g] != 2'd0) begin
          ref_mem[rq_addr[g]] = rq_data[g];
          exp_rdata = last_rdata;
        end else if (cur_lat >= 1 && cur_lat <= TIMEOUT) begin
          exp_rdata = ref_mem[rq_addr[g]];
        end else begin
          exp_rdata = 8'hFF;
          exp_terr  = 1'b1;
        end
        check($sformatf("rnd%0d_ch%0d_rdata", r, g), ch_rdata, exp_rdata);
        check($sformatf("rnd%0d_terr", r), timeout_err, exp_terr);
        last_rdata  = exp_rdata;
        model_rr    = (g + 1) % NUM_CH;
        rnd_pend[g] = 1'b0;
        step();
        set_req(g, 1'b0, 1'b0, rq_addr[g], rq_data[g]);
        cur_lat = $urandom_range(0, TIMEOUT + 2);
        mem_lat = cur_lat;
      end
    end

    repeat (3) @(negedge clk);
    check("end_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
